// File: rtl/bcd_display_scan_pkg.sv
// ============================================================================
//  Module   : bcd_display_pkg
//  Brief    : Shared segment codes, digit-select width and digit indices for
//             the multiplexed BCD display scanner.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package bcd_display_pkg;

  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] DIG0 = 2'd0;
  localparam logic [SEL_W-1:0] DIG1 = 2'd1;
  localparam logic [SEL_W-1:0] DIG2 = 2'd2;
  localparam logic [SEL_W-1:0] DIG3 = 2'd3;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

`default_nettype wire

// File: rtl/bcd_display_scan_if.sv
// ============================================================================
//  Module   : bcd_display_if
//  Brief    : Digit/control inputs and display pin outputs of the scanner.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface bcd_display_if;

  logic [3:0] bcd3;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       blank_lz;
  logic [3:0] dp_en;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output bcd3, bcd2, bcd1, bcd0, blank_lz, dp_en,
    input  seg, dp, an
  );

  modport slave (
    input  bcd3, bcd2, bcd1, bcd0, blank_lz, dp_en,
    output seg, dp, an
  );

endinterface

`default_nettype wire

// File: rtl/bcd_display_scan_bcd_to_7seg.sv
// ============================================================================
//  Module   : bcd_to_7seg
//  Brief    : Combinational BCD to active-high 7-segment decoder; codes above
//             9 show a dash.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bcd_display_scan.sv
// ============================================================================
//  Module   : bcd_display_scan
//  Brief    : 4-digit multiplexed 7-segment scanner with frame snapshot,
//             leading-zero blanking, anti-ghost gaps and pin polarity control.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_display_scan
  import bcd_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int SEG_ACT_LOW  = 1,
  parameter int AN_ACT_LOW   = 1
) (
  input  logic          clk,
  input  logic          reset,
  bcd_display_if.slave  bus
);

  localparam int               CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  sel;
  logic [3:0][3:0]   snap_digit;
  logic              snap_lz;
  logic [3:0]        snap_dp;

  logic [6:0]        seg_q;
  logic              dp_q;
  logic [3:0]        an_q;

  logic              slot_end;
  logic              frame_end;
  logic              in_gap;
  logic [3:0]        lz_hide;
  logic [3:0]        cur_digit;
  logic [6:0]        cur_seg;
  logic [6:0]        seg_d;
  logic              dp_d;
  logic [3:0]        an_d;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (sel == DIG3);

  generate
    if (BLANK_CYCLES > 0) begin : g_gap
      assign in_gap = (cnt < CNT_W'(BLANK_CYCLES));
    end else begin : g_no_gap
      assign in_gap = 1'b0;
    end
  endgenerate

  // Blanking propagates downward; a lit decimal point stops it at that digit.
  assign lz_hide[3] = snap_lz && (snap_digit[3] == 4'd0) && !snap_dp[3];
  assign lz_hide[2] = lz_hide[3] && (snap_digit[2] == 4'd0) && !snap_dp[2];
  assign lz_hide[1] = lz_hide[2] && (snap_digit[1] == 4'd0) && !snap_dp[1];
  assign lz_hide[0] = 1'b0;

  assign cur_digit = snap_digit[sel];

  bcd_to_7seg u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b0;
    an_d  = 4'b0000;
    if (!in_gap) begin
      an_d  = 4'b0001 << sel;
      dp_d  = snap_dp[sel];
      seg_d = lz_hide[sel] ? SEG_OFF : cur_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      sel        <= DIG0;
      snap_digit <= '0;
      snap_lz    <= 1'b0;
      snap_dp    <= 4'b0000;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b0;
      an_q       <= 4'b0000;
    end else begin
      cnt   <= slot_end ? '0 : cnt + 1'b1;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
      if (slot_end) begin
        sel <= sel + 1'b1;
      end
      if (frame_end) begin
        snap_digit <= {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
        snap_lz    <= bus.blank_lz;
        snap_dp    <= bus.dp_en;
      end
    end
  end

  assign bus.seg = (SEG_ACT_LOW != 0) ? ~seg_q : seg_q;
  assign bus.dp  = (SEG_ACT_LOW != 0) ? ~dp_q  : dp_q;
  assign bus.an  = (AN_ACT_LOW  != 0) ? ~an_q  : an_q;

endmodule

`default_nettype wire
